// File: rtl/alu_wide_seq.sv
// Sequencer that runs one 16-bit command as a series of byte operations on an
// external combinational 8-bit ALU. Carry/shift bits chain between the byte steps.
module alu_wide_seq #(
    parameter int BYTE_W = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  start,
    output logic                  ready,
    input  logic [2:0]            cmd,
    input  logic [2*BYTE_W-1:0]   a_in,
    input  logic [2*BYTE_W-1:0]   b_in,
    input  logic                  carry_in,
    output logic                  done,
    output logic [2*BYTE_W-1:0]   result,
    output logic                  flag,
    output logic                  overflow,
    output logic [2:0]            alu_op,
    output logic [2:0]            alu_func,
    output logic [BYTE_W-1:0]     alu_a,
    output logic [BYTE_W-1:0]     alu_b,
    output logic                  alu_flag_in,
    output logic                  alu_ovf_in,
    input  logic [BYTE_W-1:0]     alu_out,
    input  logic                  alu_flag_out,
    input  logic                  alu_ovf_out
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S1   = 3'd1;
    localparam logic [2:0] ST_S2   = 3'd2;
    localparam logic [2:0] ST_S3   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_SHL = 3'd2;
    localparam logic [2:0] CMD_SHR = 3'd3;
    localparam logic [2:0] CMD_CEQ = 3'd4;
    localparam logic [2:0] CMD_CLT = 3'd5;

    // ALU encoding; opcode 0 is the idle value driven outside the step states.
    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_ADD      = 3'd1;
    localparam logic [2:0] OP_SUB      = 3'd2;
    localparam logic [2:0] OP_OTYPE    = 3'd3;
    localparam logic [2:0] OP_CEQ      = 3'd4;
    localparam logic [2:0] OP_CLT      = 3'd5;
    localparam logic [2:0] FN_NONE     = 3'd0;
    localparam logic [2:0] FN_SHIFTL_O = 3'd1;
    localparam logic [2:0] FN_SHIFTR_O = 3'd2;

    logic [2:0]            state;
    logic [2:0]            cmd_q;
    logic [2*BYTE_W-1:0]   a_q;
    logic [2*BYTE_W-1:0]   b_q;
    logic                  ci_q;
    logic                  chain;
    logic [BYTE_W-1:0]     acc;
    logic                  f_first;
    logic                  f_second;

    logic [BYTE_W-1:0] a_lo, a_hi, b_lo, b_hi;
    assign a_lo = a_q[BYTE_W-1:0];
    assign a_hi = a_q[2*BYTE_W-1:BYTE_W];
    assign b_lo = b_q[BYTE_W-1:0];
    assign b_hi = b_q[2*BYTE_W-1:BYTE_W];

    assign ready       = (state == ST_IDLE);
    assign done        = (state == ST_DONE);
    assign alu_flag_in = 1'b0;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_op     = OP_NOP;
        alu_func   = FN_NONE;
        alu_a      = '0;
        alu_b      = '0;
        alu_ovf_in = 1'b0;
        case (state)
            ST_S1: begin
                case (cmd_q)
                    CMD_ADD, CMD_SUB: begin
                        alu_op     = (cmd_q == CMD_ADD) ? OP_ADD : OP_SUB;
                        alu_a      = a_lo;
                        alu_b      = b_lo;
                        alu_ovf_in = ci_q;
                    end
                    CMD_SHL: begin
                        alu_op     = OP_OTYPE;
                        alu_func   = FN_SHIFTL_O;
                        alu_a      = a_lo;
                        alu_ovf_in = ci_q;
                    end
                    CMD_SHR: begin
                        alu_op     = OP_OTYPE;
                        alu_func   = FN_SHIFTR_O;
                        alu_a      = a_hi;
                        alu_ovf_in = ci_q;
                    end
                    CMD_CEQ: begin
                        alu_op = OP_CEQ;
                        alu_a  = a_lo;
                        alu_b  = b_lo;
                    end
                    CMD_CLT: begin
                        alu_op = OP_CLT;
                        alu_a  = a_hi;
                        alu_b  = b_hi;
                    end
                    default: ;
                endcase
            end
            ST_S2: begin
                case (cmd_q)
                    CMD_ADD, CMD_SUB: begin
                        alu_op     = (cmd_q == CMD_ADD) ? OP_ADD : OP_SUB;
                        alu_a      = a_hi;
                        alu_b      = b_hi;
                        alu_ovf_in = chain;
                    end
                    CMD_SHL: begin
                        alu_op     = OP_OTYPE;
                        alu_func   = FN_SHIFTL_O;
                        alu_a      = a_hi;
                        alu_ovf_in = chain;
                    end
                    CMD_SHR: begin
                        alu_op     = OP_OTYPE;
                        alu_func   = FN_SHIFTR_O;
                        alu_a      = a_lo;
                        alu_ovf_in = chain;
                    end
                    CMD_CEQ, CMD_CLT: begin
                        alu_op = OP_CEQ;
                        alu_a  = a_hi;
                        alu_b  = b_hi;
                    end
                    default: ;
                endcase
            end
            ST_S3: begin
                alu_op = OP_CLT;
                alu_a  = a_lo;
                alu_b  = b_lo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ST_IDLE;
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ci_q     <= 1'b0;
            chain    <= 1'b0;
            acc      <= '0;
            f_first  <= 1'b0;
            f_second <= 1'b0;
            result   <= '0;
            flag     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cmd_q <= cmd;
                        a_q   <= a_in;
                        b_q   <= b_in;
                        ci_q  <= carry_in;
                        state <= ST_S1;
                    end
                end
                ST_S1: begin
                    chain   <= alu_ovf_out;
                    acc     <= alu_out;
                    f_first <= alu_flag_out;
                    if (cmd_q > CMD_CLT) begin
                        result   <= '0;
                        flag     <= 1'b0;
                        overflow <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        state <= ST_S2;
                    end
                end
                ST_S2: begin
                    state <= ST_DONE;
                    case (cmd_q)
                        CMD_SHR: begin
                            // SHR walks high byte first, so the S1 byte is the upper half.
                            result   <= {acc, alu_out};
                            overflow <= alu_ovf_out;
                        end
                        CMD_CEQ: begin
                            result   <= '0;
                            flag     <= f_first & alu_flag_out;
                            overflow <= 1'b0;
                        end
                        CMD_CLT: begin
                            f_second <= alu_flag_out;
                            state    <= ST_S3;
                        end
                        default: begin
                            result   <= {alu_out, acc};
                            overflow <= alu_ovf_out;
                        end
                    endcase
                end
                ST_S3: begin
                    result   <= '0;
                    flag     <= f_first | (f_second & alu_flag_out);
                    overflow <= 1'b0;
                    state    <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq; a behavioural 8-bit ALU model answers the
// sequencer's byte operations and every expected value is hand-computed.
module tb_alu_wide_seq;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        ready;
    logic [2:0]  cmd = 3'd0;
    logic [15:0] a_in = 16'h0;
    logic [15:0] b_in = 16'h0;
    logic        carry_in = 1'b0;
    logic        done;
    logic [15:0] result;
    logic        flag;
    logic        overflow;
    logic [2:0]  alu_op;
    logic [2:0]  alu_func;
    logic [7:0]  alu_a, alu_b;
    logic        alu_flag_in, alu_ovf_in;
    logic [7:0]  alu_out;
    logic        alu_flag_out, alu_ovf_out;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    alu_wide_seq #(.BYTE_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .ready(ready), .cmd(cmd),
        .a_in(a_in), .b_in(b_in), .carry_in(carry_in), .done(done),
        .result(result), .flag(flag), .overflow(overflow),
        .alu_op(alu_op), .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
        .alu_flag_in(alu_flag_in), .alu_ovf_in(alu_ovf_in),
        .alu_out(alu_out), .alu_flag_out(alu_flag_out), .alu_ovf_out(alu_ovf_out)
    );

    // Behavioural ALU: 1=ADD 2=SUB 3=O-type (func 1=SHL, 2=SHR) 4=CEQ 5=CLT.
    logic [8:0] wide;
    always_comb begin
        wide         = 9'h0;
        alu_out      = 8'h0;
        alu_flag_out = 1'b0;
        alu_ovf_out  = 1'b0;
        case (alu_op)
            3'd1: begin
                wide = {1'b0, alu_a} + {1'b0, alu_b} + {8'h0, alu_ovf_in};
                alu_out = wide[7:0]; alu_ovf_out = wide[8];
            end
            3'd2: begin
                wide = {1'b0, alu_a} - {1'b0, alu_b} - {8'h0, alu_ovf_in};
                alu_out = wide[7:0]; alu_ovf_out = wide[8];
            end
            3'd3: begin
                if (alu_func == 3'd1) begin
                    alu_out = {alu_a[6:0], alu_ovf_in}; alu_ovf_out = alu_a[7];
                end else if (alu_func == 3'd2) begin
                    alu_out = {alu_ovf_in, alu_a[7:1]}; alu_ovf_out = alu_a[0];
                end
            end
            3'd4: alu_flag_out = (alu_a == alu_b);
            3'd5: alu_flag_out = (alu_a < alu_b);
            default: ;
        endcase
    end

    // Waits for IDLE, presents a command and returns #1 after the accept edge (cycle 1 = S1).
    task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                         input logic ci);
        int guard = 0;
        while (!ready && guard < 20) begin
            @(posedge CLK); #1; guard++;
        end
        cmd = c; a_in = a; b_in = b; carry_in = ci; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    // Advances until done is seen; cyc is the cycle index where it appeared (20 = timeout).
    task automatic wait_done(input int cur, output int cyc);
        cyc = cur;
        while (!done && cyc < 20) begin
            @(posedge CLK); #1; cyc++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b1; cmd = 3'd0; a_in = 16'hFFFF; b_in = 16'hFFFF;
        repeat (3) @(posedge CLK);
        #1; Reset = 1'b0; start = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 16'h0) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
        checks++; if ({flag, overflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {flag, overflow}); end
        checks++; if ({alu_op, alu_a, alu_b} !== 19'h0) begin failures++; $display("FAIL reset_alu_idle got=%h exp=0", {alu_op, alu_a, alu_b}); end
    endtask

    task automatic test_add();
        int cyc;
        issue(3'd0, 16'h00FF, 16'h0001, 1'b0);
        checks++; if ({alu_op, alu_a, alu_b, alu_ovf_in} !== {3'd1, 8'hFF, 8'h01, 1'b0}) begin
            failures++; $display("FAIL add_s1_drive got=%h/%h/%h/%b exp=1/ff/01/0", alu_op, alu_a, alu_b, alu_ovf_in); end
        @(posedge CLK); #1;
        checks++; if ({alu_op, alu_a, alu_b, alu_ovf_in} !== {3'd1, 8'h00, 8'h00, 1'b1}) begin
            failures++; $display("FAIL add_s2_drive got=%h/%h/%h/%b exp=1/00/00/1", alu_op, alu_a, alu_b, alu_ovf_in); end
        wait_done(2, cyc);
        checks++; if (cyc !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", cyc); end
        checks++; if ({result, overflow} !== {16'h0100, 1'b0}) begin failures++; $display("FAIL add_carry_chain got=%h/%b exp=0100/0", result, overflow); end
        checks++; if ({alu_op, alu_a} !== 11'h0) begin failures++; $display("FAIL add_done_idle got=%h exp=0", {alu_op, alu_a}); end

        issue(3'd0, 16'hFFFF, 16'h0001, 1'b0);
        wait_done(1, cyc);
        checks++; if ({result, overflow} !== {16'h0000, 1'b1}) begin failures++; $display("FAIL add_wrap got=%h/%b exp=0000/1", result, overflow); end

        issue(3'd0, 16'h1234, 16'h1111, 1'b1);
        wait_done(1, cyc);
        checks++; if ({result, overflow} !== {16'h2346, 1'b0}) begin failures++; $display("FAIL add_carry_in got=%h/%b exp=2346/0", result, overflow); end
    endtask

    task automatic test_shift();
        int cyc;
        issue(3'd2, 16'h8001, 16'h0000, 1'b1);
        wait_done(1, cyc);
        checks++; if ({result, overflow} !== {16'h0003, 1'b1}) begin failures++; $display("FAIL shl got=%h/%b exp=0003/1", result, overflow); end

        issue(3'd3, 16'h0003, 16'h0000, 1'b0);
        checks++; if ({alu_op, alu_func, alu_a} !== {3'd3, 3'd2, 8'h00}) begin
            failures++; $display("FAIL shr_s1_high_byte got=%h/%h/%h exp=3/2/00", alu_op, alu_func, alu_a); end
        wait_done(1, cyc);
        checks++; if ({result, overflow} !== {16'h0001, 1'b1}) begin failures++; $display("FAIL shr got=%h/%b exp=0001/1", result, overflow); end
    endtask

    task automatic test_compare();
        int cyc;
        issue(3'd5, 16'h0100, 16'h00FF, 1'b0);
        wait_done(1, cyc);
        checks++; if (cyc !== 4) begin failures++; $display("FAIL clt_latency got=%0d exp=4", cyc); end
        checks++; if ({flag, overflow, result} !== {1'b0, 1'b0, 16'h0}) begin
            failures++; $display("FAIL clt_hi_greater got=%b/%b/%h exp=0/0/0000", flag, overflow, result); end

        issue(3'd5, 16'h00FE, 16'h00FF, 1'b0);
        wait_done(1, cyc);
        checks++; if (flag !== 1'b1) begin failures++; $display("FAIL clt_lo_less got=%b exp=1", flag); end

        issue(3'd4, 16'hA5A5, 16'hA5A4, 1'b0);
        wait_done(1, cyc);
        checks++; if ({cyc, flag} !== {32'd3, 1'b0}) begin failures++; $display("FAIL ceq_ne got=%0d/%b exp=3/0", cyc, flag); end

        issue(3'd4, 16'hA5A5, 16'hA5A5, 1'b0);
        wait_done(1, cyc);
        checks++; if ({flag, result} !== {1'b1, 16'h0}) begin failures++; $display("FAIL ceq_eq got=%b/%h exp=1/0000", flag, result); end
    endtask

    task automatic test_sub();
        int cyc;
        issue(3'd1, 16'h0100, 16'h0001, 1'b0);
        wait_done(1, cyc);
        checks++; if ({result, overflow} !== {16'h00FF, 1'b0}) begin failures++; $display("FAIL sub_borrow got=%h/%b exp=00ff/0", result, overflow); end
        checks++; if (flag !== 1'b1) begin failures++; $display("FAIL sub_flag_held got=%b exp=1", flag); end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        issue(3'd0, 16'h0001, 16'h0001, 1'b0);
        cmd = 3'd1; a_in = 16'hFFFF; b_in = 16'h1234; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                dones++;
                checks++; if (result !== 16'h0002) begin failures++; $display("FAIL ignore_result got=%h exp=0002", result); end
            end
            @(posedge CLK); #1;
            start = 1'b0;
        end
        checks++; if (dones !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] seen = '0;
        issue(3'd0, 16'h0005, 16'h0003, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            if (c == 5) start = 1'b0;
            seen[c] = done;
            if (c == 4) begin
                checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=1", ready); end
            end
            @(posedge CLK); #1;
        end
        checks++; if (seen !== 10'b0010001000) begin failures++; $display("FAIL b2b_done_cycles got=%b exp=0010001000", seen); end
        checks++; if (result !== 16'h0008) begin failures++; $display("FAIL b2b_result got=%h exp=0008", result); end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        issue(3'd0, 16'h0001, 16'h0001, 1'b0);
        @(posedge CLK); #1;
        Reset = 1'b1; start = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0; start = 1'b0;
        checks++; if ({ready, done, result} !== {1'b1, 1'b0, 16'h0}) begin
            failures++; $display("FAIL abort_state got=%b/%b/%h exp=1/0/0000", ready, done, result); end
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            @(posedge CLK); #1;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    endtask

    task automatic test_illegal();
        int cyc;
        issue(3'd4, 16'h1111, 16'h1111, 1'b0);
        wait_done(1, cyc);
        issue(3'd0, 16'hFFFF, 16'h0002, 1'b0);
        wait_done(1, cyc);
        checks++; if ({result, flag, overflow} !== {16'h0001, 1'b1, 1'b1}) begin
            failures++; $display("FAIL illegal_setup got=%h/%b/%b exp=0001/1/1", result, flag, overflow); end
        issue(3'd7, 16'hBEEF, 16'hCAFE, 1'b1);
        checks++; if ({alu_op, alu_a, alu_b, alu_ovf_in} !== 20'h0) begin
            failures++; $display("FAIL illegal_s1_drive got=%h exp=0", {alu_op, alu_a, alu_b, alu_ovf_in}); end
        wait_done(1, cyc);
        checks++; if (cyc !== 2) begin failures++; $display("FAIL illegal_latency got=%0d exp=2", cyc); end
        checks++; if ({result, flag, overflow} !== 18'h0) begin
            failures++; $display("FAIL illegal_zeros got=%h/%b/%b exp=0000/0/0", result, flag, overflow); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_compare();
        test_sub();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
- Multi-precision sequencer that acts as the initiator driving the combinational 8-bit ALU.
- Accepts one 16-bit command and issues it to the ALU as successive byte operations.
- Chains OVERFLOW_OUT into OVERFLOW_IN between steps and merges per-byte compare flags.
- Returns a 16-bit result with final flag/overflow; sits between the control unit and the ALU.

Parameters:
BYTE_W, 8, ALU datapath width; only 8 supported, result width 2*BYTE_W.

Ports:
CLK  in  1  clock, rising edge.
Reset  in  1  synchronous, active-high.
start  in  1  command valid; accepted only when ready=1.
ready  out  1  high in IDLE only.
cmd  in  3  0=ADD 1=SUB 2=SHL 3=SHR 4=CEQ 5=CLT (unsigned); 6,7 illegal.
a_in  in  16  operand A, sampled at accept.
b_in  in  16  operand B, sampled at accept.
carry_in  in  1  initial carry/shift-in, sampled at accept.
done  out  1  one-cycle pulse, result/flag/overflow valid.
result  out  16  held until next done.
flag  out  1  compare result, held.
overflow  out  1  final carry/shift-out, held.
alu_op  out  3  to ALU OP.
alu_func  out  3  to ALU FUNC.
alu_a, alu_b  out  8  to INPUTA/INPUTB.
alu_flag_in  out  1  to FLAG_IN (always 0).
alu_ovf_in  out  1  to OVERFLOW_IN.
alu_out  in  8  from OUT.
alu_flag_out  in  1  from FLAG_OUT.
alu_ovf_out  in  1  from OVERFLOW_OUT.

Behaviour:
- Reset: state IDLE; result=0, flag=0, overflow=0, done=0, chain reg=0, latched operands=0. Reset mid-operation aborts with no done pulse. ready=1 in the first cycle after the Reset edge. start is ignored while Reset=1.
- States: IDLE, S1, S2, S3, DONE.
  - IDLE & start: latch cmd/a/b/carry_in → S1.
  - start outside IDLE is ignored; it is neither queued nor able to corrupt latched operands.
- ALU step timing: each S-state is one ALU step. The ALU is combinational; its outputs are captured at the end of that state's cycle.
- ADD/SUB: alu_op=opADD/opSUB.
  - S1: low bytes, alu_ovf_in=carry_in.
  - S2: high bytes, alu_ovf_in=chain.
  - Capture OUT into result[7:0] then [15:8]. overflow=S2 alu_ovf_out.
- SHL: alu_op=O-type opcode, alu_func=fnSHIFTL_O.
  - S1 low byte, ovf_in=carry_in.
  - S2 high byte, ovf_in=chain.
  - overflow=old bit15.
- SHR: alu_func=fnSHIFTR_O, high byte first.
  - S1 high byte, ovf_in=carry_in.
  - S2 low byte, ovf_in=chain.
  - overflow=old bit0.
- CEQ:
  - S1 opCEQ low, S2 opCEQ high.
  - flag=eq_lo & eq_hi; result=0; overflow=0.
- CLT:
  - S1 opCLT high (lt_hi), S2 opCEQ high (eq_hi), S3 opCLT low (lt_lo).
  - flag=lt_hi | (eq_hi & lt_lo); result=0; overflow=0.
- Sequencing: ADD/SUB/SHL/SHR/CEQ go S1→S2→DONE. CLT goes S1→S2→S3→DONE. Illegal cmd goes S1→DONE with result=0, flag=0, overflow=0 and drives no ALU op in S1.
- Latency (start accepted at edge N): done=1 during cycle N+3 (CLT: N+4; illegal: N+2). DONE→IDLE unconditionally, so back-to-back commands have a 1-cycle IDLE gap.
- Output update: result/flag/overflow update only on entry to DONE. flag is untouched by ADD/SUB/shift. overflow is untouched by nothing; compares write 0.
- Idle drive: in IDLE/DONE all alu_* outputs = 0.

Test Plan:
- ADD a=0x00FF b=0x0001 ci=0:
  - S1 drives alu_a=FF alu_b=01 ovf_in=0.
  - S2 drives 00/00 ovf_in=1.
  - done at N+3, result=0x0100, overflow=0.
- ADD 0xFFFF+0x0001 ci=0 → result=0x0000, overflow=1. ADD 0x1234+0x1111 ci=1 → 0x2346, overflow=0.
- SHL a=0x8001 ci=1 → result=0x0003, overflow=1. SHR a=0x0003 ci=0 → S1 alu_a=0x00, result=0x0001, overflow=1.
- CLT:
  - 0x0100 vs 0x00FF → flag=0, done at N+4.
  - 0x00FE vs 0x00FF → flag=1.
  - CEQ 0xA5A5 vs 0xA5A4 → flag=0.
  - CEQ 0xA5A5 vs 0xA5A5 → flag=1, result=0.
- Control/abort:
  - start pulsed during S1 of an ADD is ignored; exactly one done.
  - Reset asserted in S2 → no done, result=0, ready=1 next cycle.
  - cmd=7 → done at N+2 with zeros.
